// File: rtl/div_master_pkg.sv
// Shared types and constants for the divider bus master.
package div_master_pkg;

    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] DIVZ_QUOTIENT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_Q,
        LOAD_M,
        WAIT_DONE,
        READ_R,
        READ_Q,
        RESP
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] q;
        logic [WORD_W-1:0] m;
    } operands_t;

endpackage

// File: rtl/div_watchdog.sv
// Cycle counter for WAIT_DONE; expired fires on the LIMIT-th enabled cycle.
module div_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + CNT_W'(1);
    end

    // Combinational so the abort lands on the same edge as the last counted cycle.
    assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/div_bus_master.sv
// Sequences operand words into an 8-bit divider bus and collects its results.
// Optional DIV_TIMEOUT_EN adds a WAIT_DONE watchdog of TIMEOUT_CYCLES.
module div_bus_master
    import div_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2*WORD_W-1:0] dividend,
    input  logic [WORD_W-1:0]   divisor,
    output logic                div_enable,
    output logic [WORD_W-1:0]   div_inbus,
    input  logic                div_done,
    input  logic [WORD_W-1:0]   div_outbus,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WORD_W-1:0]   quotient,
    output logic [WORD_W-1:0]   remainder,
    output logic                resp_err
);

    state_t    state, state_nxt;
    operands_t ops;
    logic      timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef DIV_TIMEOUT_EN
    div_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != WAIT_DONE),
        .enable (state == WAIT_DONE),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        div_enable = 1'b0;
        div_inbus  = '0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = (divisor == '0) ? RESP : LOAD_A;
            end
            LOAD_A: begin
                div_enable = 1'b1;
                div_inbus  = ops.a;
                state_nxt  = LOAD_Q;
            end
            LOAD_Q: begin
                div_inbus = ops.q;
                state_nxt = LOAD_M;
            end
            LOAD_M: begin
                div_inbus = ops.m;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A completing divider wins over a simultaneous timeout.
                if (div_done)
                    state_nxt = READ_R;
                else if (timeout)
                    state_nxt = RESP;
            end
            READ_R: state_nxt = READ_Q;
            READ_Q: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops       <= '0;
            quotient  <= '0;
            remainder <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ops <= {dividend, divisor};
                        if (divisor == '0) begin
                            quotient  <= DIVZ_QUOTIENT;
                            remainder <= dividend[WORD_W-1:0];
                            resp_err  <= 1'b1;
                        end else begin
                            resp_err  <= 1'b0;
                        end
                    end
                end
                WAIT_DONE: begin
                    // Divider presents the remainder first, quotient one cycle later.
                    if (div_done) begin
                        remainder <= div_outbus;
                    end else if (timeout) begin
                        quotient  <= '0;
                        remainder <= '0;
                        resp_err  <= 1'b1;
                    end
                end
                READ_R: quotient <= div_outbus;
                default: ;
            endcase
        end
    end

endmodule
